horner_ctrl: RTL and testbench

- Parametrised control block (BC successor) that sequences the polynomial datapath to compute y = a_d*x^d + ... + a_1*x + a_0 by Horner's rule.
- The degree d is selectable at run time, up to the DEGREE parameter.
- Drives the datapath load enables, operand mux selects, the coefficient index and the mul/add mode.
- Adds what the fixed 7-state controller lacked: a start/busy/done handshake, an iteration counter, abort, and degree clamping.
- Sits between the top-level sequencer and the multiply/add datapath (x, acc and tmp registers).

---
 rtl/horner_ctrl.sv | 150 +++++++++++++++
 tb/tb_horner_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/horner_ctrl.sv
// Horner's-rule sequencer for the polynomial datapath: drives x/tmp/acc load enables, ALU operand
// selects, coefficient index and mul/add mode, with start/busy/done handshake, abort and clamping.
module horner_ctrl #(
  parameter int unsigned DEGREE = 3,
  parameter int unsigned CNT_W  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] degree_in,
  output logic             busy,
  output logic             done,
  output logic             deg_clamped,
  output logic             ld_x,
  output logic             ld_tmp,
  output logic             ld_acc,
  output logic             op_mul,
  output logic [1:0]       sel_a,
  output logic [1:0]       sel_b,
  output logic [CNT_W-1:0] coef_idx
);

  localparam logic [CNT_W-1:0] DegMax = CNT_W'(DEGREE);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StLoadX = 3'd1,
    StInit  = 3'd2,
    StMul   = 3'd3,
    StAdd   = 3'd4,
    StDone  = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] deg_q, deg_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic             clamp_q, clamp_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      deg_q   <= '0;
      idx_q   <= '0;
      clamp_q <= 1'b0;
    end else begin
      state_q <= state_d;
      deg_q   <= deg_d;
      idx_q   <= idx_d;
      clamp_q <= clamp_d;
    end
  end

  always_comb begin
    state_d = state_q;
    deg_d   = deg_q;
    idx_d   = idx_q;
    clamp_d = clamp_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StLoadX;
          if (degree_in > DegMax) begin
            deg_d   = DegMax;
            clamp_d = 1'b1;
          end else begin
            deg_d   = degree_in;
            clamp_d = 1'b0;
          end
        end
      end
      StLoadX: state_d = StInit;
      StInit: begin
        if (deg_q == '0) begin
          state_d = StDone;
        end else begin
          idx_d   = deg_q - CNT_W'(1);
          state_d = StMul;
        end
      end
      StMul: state_d = StAdd;
      StAdd: begin
        // idx==0 exits before the decrement, so idx never wraps
        if (idx_q == '0) begin
          state_d = StDone;
        end else begin
          idx_d   = idx_q - CNT_W'(1);
          state_d = StMul;
        end
      end
      StDone: begin
        state_d = StIdle;
        clamp_d = 1'b0;
      end
      default: begin
        state_d = StIdle;
        clamp_d = 1'b0;
      end
    endcase
    if (abort && (state_q inside {StLoadX, StInit, StMul, StAdd})) begin
      state_d = StIdle;
      clamp_d = 1'b0;
    end
  end

  always_comb begin
    busy        = 1'b0;
    done        = 1'b0;
    deg_clamped = 1'b0;
    ld_x        = 1'b0;
    ld_tmp      = 1'b0;
    ld_acc      = 1'b0;
    op_mul      = 1'b0;
    sel_a       = 2'd0;
    sel_b       = 2'd0;
    coef_idx    = '0;
    case (state_q)
      StLoadX: begin
        busy = 1'b1;
        ld_x = 1'b1;
      end
      StInit: begin
        busy     = 1'b1;
        ld_acc   = 1'b1;
        sel_b    = 2'd2;
        coef_idx = deg_q;
      end
      StMul: begin
        busy   = 1'b1;
        ld_tmp = 1'b1;
        op_mul = 1'b1;
        sel_a  = 2'd1;
        sel_b  = 2'd1;
      end
      StAdd: begin
        busy     = 1'b1;
        ld_acc   = 1'b1;
        sel_a    = 2'd2;
        sel_b    = 2'd2;
        coef_idx = idx_q;
      end
      StDone: begin
        done        = 1'b1;
        deg_clamped = clamp_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_horner_ctrl.sv
// Bench for horner_ctrl: a datapath model follows the controls, and the expected acc from a direct
// power-sum evaluation is queued at start and compared when done pulses.
module tb_horner_ctrl;

  localparam int unsigned DEGREE = 3;
  localparam int unsigned CNT_W  = 4;

  logic             clk = 1'b0;
  logic             reset, start, abort;
  logic [CNT_W-1:0] degree_in;
  logic             busy, done, deg_clamped, ld_x, ld_tmp, ld_acc, op_mul;
  logic [1:0]       sel_a, sel_b;
  logic [CNT_W-1:0] coef_idx;
  logic [10+CNT_W:0] outs;

  horner_ctrl #(.DEGREE(DEGREE), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .degree_in(degree_in),
    .busy(busy), .done(done), .deg_clamped(deg_clamped), .ld_x(ld_x), .ld_tmp(ld_tmp),
    .ld_acc(ld_acc), .op_mul(op_mul), .sel_a(sel_a), .sel_b(sel_b), .coef_idx(coef_idx)
  );

  assign outs = {busy, done, deg_clamped, ld_x, ld_tmp, ld_acc, op_mul, sel_a, sel_b, coef_idx};

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // datapath model: x, tmp, acc registers and the ALU
  int xin = 3;
  int coef [0:DEGREE];
  int x_m = 0, tmp_m = 0, acc_m = 0;
  int alu_a, alu_b, alu_r;

  always_comb begin
    alu_a = 0;
    alu_b = 0;
    case (sel_a)
      2'd1: alu_a = acc_m;
      2'd2: alu_a = tmp_m;
      2'd3: alu_a = x_m;
      default: alu_a = 0;
    endcase
    case (sel_b)
      2'd1: alu_b = x_m;
      2'd2: alu_b = (int'(coef_idx) <= DEGREE) ? coef[coef_idx] : -1;
      default: alu_b = 0;
    endcase
    alu_r = op_mul ? alu_a * alu_b : alu_a + alu_b;
  end

  always @(posedge clk) begin
    if (ld_x)   x_m   <= xin;
    if (ld_tmp) tmp_m <= alu_r;
    if (ld_acc) acc_m <= alu_r;
  end

  typedef struct {
    int acc;
    int clamp;
  } exp_t;
  exp_t sb[$];

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int poly(input int d);
    int s = 0;
    int p = 1;
    for (int i = 0; i <= d; i++) begin
      s += coef[i] * p;
      p *= xin;
    end
    return s;
  endfunction

  task automatic push_exp(input int d, input int clamp);
    exp_t e;
    e.acc   = poly(d);
    e.clamp = clamp;
    sb.push_back(e);
  endtask

  task automatic check_done(input string tag);
    exp_t e;
    chk({tag, "_sb_nonempty"}, int'(sb.size() != 0), 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_acc"}, acc_m, e.acc);
      chk({tag, "_clamp"}, int'(deg_clamped), e.clamp);
    end
  endtask

  // One evaluation from a start pulse; a stray start pulse is injected while busy.
  task automatic run_eval(input string tag, input int d_in, input int d_eff, input int clamp,
                          input logic ab);
    int k, nbusy, maxidx;
    bit tmp_seen, got;
    @(negedge clk);
    start     = 1'b1;
    abort     = ab;
    degree_in = CNT_W'(d_in);
    push_exp(d_eff, clamp);
    @(negedge clk);
    k         = cyc;
    start     = 1'b0;
    abort     = 1'b0;
    degree_in = '0;
    nbusy = 0; maxidx = 0; tmp_seen = 0; got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (busy) nbusy++;
      if (ld_tmp) tmp_seen = 1;
      if (int'(coef_idx) > maxidx) maxidx = int'(coef_idx);
      if (done) got = 1;
      else begin
        start = (i == 1);
        @(negedge clk);
      end
    end
    start = 1'b0;
    chk({tag, "_done_seen"}, int'(got), 1);
    if (got) begin
      chk({tag, "_latency"}, cyc - k, 2 * d_eff + 2);
      chk({tag, "_busy_cycles"}, nbusy, 2 * d_eff + 2);
      chk({tag, "_max_idx"}, maxidx, d_eff);
      chk({tag, "_mul_seen"}, int'(tmp_seen), int'(d_eff != 0));
      check_done(tag);
      @(negedge clk);
      chk({tag, "_done_pulse"}, int'(done), 0);
    end
  endtask

  initial begin
    int nmul, ndone;
    int t [0:2];
    bit hit;
    coef      = '{1, 2, 1, 5};
    reset     = 1'b1;
    start     = 1'b1;
    abort     = 1'b0;
    degree_in = 4'd2;

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset_outs", int'(outs), 0);
    end
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("idle_outs", int'(outs), 0);

    xin = 3;
    run_eval("d2", 2, 2, 0, 1'b0);
    run_eval("d0", 0, 0, 0, 1'b0);
    xin = 2;
    run_eval("clamp7", 7, 3, 1, 1'b0);

    // abort in the second MUL of a clamped d=3 run
    @(negedge clk);
    start     = 1'b1;
    degree_in = 4'd7;
    @(negedge clk);
    start = 1'b0;
    nmul  = 0;
    hit   = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      if (ld_tmp) nmul++;
      if (nmul == 2) begin
        abort = 1'b1;
        hit   = 1;
      end else @(negedge clk);
    end
    chk("abort_reached_mul2", int'(hit), 1);
    @(negedge clk);
    abort = 1'b0;
    chk("abort_outs", int'(outs), 0);
    @(negedge clk);
    chk("abort_no_done", int'(outs), 0);
    xin = 3;
    run_eval("after_abort", 3, 3, 0, 1'b1);

    // start held high: back-to-back d=1 evaluations
    @(negedge clk);
    start     = 1'b1;
    degree_in = 4'd1;
    for (int j = 0; j < 3; j++) push_exp(1, 0);
    ndone = 0;
    for (int i = 0; i < 60 && ndone < 3; i++) begin
      @(negedge clk);
      if (done) begin
        t[ndone] = cyc;
        ndone++;
        check_done("held");
        if (ndone == 3) start = 1'b0;
      end
    end
    chk("held_done_count", ndone, 3);
    if (ndone == 3) begin
      chk("held_period_1", t[1] - t[0], 2 * 1 + 4);
      chk("held_period_2", t[2] - t[1], 2 * 1 + 4);
    end
    @(negedge clk);
    @(negedge clk);
    chk("held_stopped", int'(busy), 0);

    // reset mid-ADD, with start asserted alongside
    @(negedge clk);
    start     = 1'b1;
    degree_in = 4'd2;
    @(negedge clk);
    start = 1'b0;
    hit   = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      if (ld_acc && sel_a == 2'd2) hit = 1;
      else @(negedge clk);
    end
    chk("reached_add", int'(hit), 1);
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    chk("reset_mid_add_outs", int'(outs), 0);
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("reset_start_ignored", int'(outs), 0);
    run_eval("post_reset", 1, 1, 0, 1'b0);

    chk("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
